// File: rtl/video_ram_dp.sv
// True-dual-port video RAM: registered input stage, optional output register,
// and a clear engine that sweeps CLEAR_VALUE through the array after reset or on request.
module video_ram_dp #(
   parameter int                    DATA_WIDTH  = 4,
   parameter int                    ADDR_WIDTH  = 8,
   parameter int                    OUTPUT_REG  = 0,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  clear,
   output logic                  busy,
   input  logic [ADDR_WIDTH-1:0] address_a,
   input  logic [DATA_WIDTH-1:0] data_a,
   input  logic                  wren_a,
   output logic [DATA_WIDTH-1:0] q_a,
   input  logic [ADDR_WIDTH-1:0] address_b,
   input  logic [DATA_WIDTH-1:0] data_b,
   input  logic                  wren_b,
   output logic [DATA_WIDTH-1:0] q_b
);
   localparam int                  NPORT     = 2;
   localparam int                  DEPTH     = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH+1)'(DEPTH - 1);

   typedef enum logic {S_CLEAR, S_IDLE} state_t;

   state_t              state_q, state_d;
   logic [ADDR_WIDTH:0] clr_addr_q, clr_addr_d;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_WIDTH-1:0] port_addr [NPORT];
   logic [DATA_WIDTH-1:0] port_data [NPORT];
   logic                  port_wren [NPORT];
   logic [DATA_WIDTH-1:0] port_q    [NPORT];
   logic [ADDR_WIDTH-1:0] wr_addr   [NPORT];
   logic [DATA_WIDTH-1:0] wr_data   [NPORT];
   logic                  wr_en     [NPORT];

   assign port_addr[0] = address_a;
   assign port_data[0] = data_a;
   assign port_wren[0] = wren_a;
   assign port_addr[1] = address_b;
   assign port_data[1] = data_b;
   assign port_wren[1] = wren_b;
   assign q_a          = port_q[0];
   assign q_b          = port_q[1];

   // Clear engine: the extra address bit keeps the terminal compare from aliasing.
   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      case (state_q)
         S_CLEAR: begin
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == LAST_ADDR) begin
               state_d = S_IDLE;
            end
         end
         S_IDLE: begin
            if (clear) begin
               state_d    = S_CLEAR;
               clr_addr_d = '0;
            end
         end
         default: state_d = S_CLEAR;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_CLEAR;
         clr_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
      end
   end

   assign busy = (state_q == S_CLEAR);

   for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
      logic [ADDR_WIDTH-1:0] addr_q, addr_d;
      logic [DATA_WIDTH-1:0] data_q, data_d;
      logic                  wren_q, wren_d;
      logic [DATA_WIDTH-1:0] rd_word;

      // Writes captured while sweeping are dropped here, before they can commit.
      always_comb begin
         addr_d = port_addr[gi];
         data_d = port_data[gi];
         wren_d = port_wren[gi] & ~busy;
      end

      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            addr_q <= '0;
            data_q <= '0;
            wren_q <= 1'b0;
         end else begin
            addr_q <= addr_d;
            data_q <= data_d;
            wren_q <= wren_d;
         end
      end

      assign wr_addr[gi] = addr_q;
      assign wr_data[gi] = data_q;
      assign wr_en[gi]   = wren_q;
      assign rd_word     = mem[addr_q];

      if (OUTPUT_REG != 0) begin : g_oreg
         logic [DATA_WIDTH-1:0] out_q, out_d;

         always_comb begin
            out_d = busy ? '0 : rd_word;
         end

         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               out_q <= '0;
            end else begin
               out_q <= out_d;
            end
         end

         assign port_q[gi] = busy ? '0 : out_q;
      end else begin : g_direct
         assign port_q[gi] = busy ? '0 : rd_word;
      end
   end

   // Port A is assigned last so it takes priority on a same-address collision.
   always_ff @(posedge clock) begin
      if (busy) begin
         mem[clr_addr_q[ADDR_WIDTH-1:0]] <= CLEAR_VALUE;
      end else begin
         if (wr_en[1]) begin
            mem[wr_addr[1]] <= wr_data[1];
         end
         if (wr_en[0]) begin
            mem[wr_addr[0]] <= wr_data[0];
         end
      end
   end

endmodule
